// File: rtl/alu_ops_pkg.sv
// ALU micro-op codes shared with the decode stage, plus RV64 opcode constants
// used when turning those codes back into instruction words.
package alu_ops_pkg;

  typedef enum logic [5:0] {
    AluNop    = 6'h00,
    AluAddi   = 6'h01, AluSlti  = 6'h02, AluSltiu = 6'h03, AluXori  = 6'h04,
    AluOri    = 6'h05, AluAndi  = 6'h06, AluSlli  = 6'h07, AluSrli  = 6'h08,
    AluSrai   = 6'h09,
    AluAdd    = 6'h0C, AluSub   = 6'h0D, AluSll   = 6'h0E, AluSlt   = 6'h0F,
    AluSltu   = 6'h10, AluXor   = 6'h11, AluSrl   = 6'h12, AluSra   = 6'h13,
    AluOr     = 6'h14, AluAnd   = 6'h15,
    AluAddiw  = 6'h16, AluSlliw = 6'h17, AluSrliw = 6'h18, AluSraiw = 6'h19,
    AluAddw   = 6'h1A, AluSubw  = 6'h1B, AluSllw  = 6'h1C, AluSrlw  = 6'h1D,
    AluSraw   = 6'h1E,
    AluMul    = 6'h1F, AluMulh  = 6'h20, AluMulhsu = 6'h21, AluMulhu = 6'h22,
    AluDiv    = 6'h23, AluDivu  = 6'h24, AluRem   = 6'h25, AluRemu  = 6'h26,
    AluMulw   = 6'h27, AluDivw  = 6'h28, AluDivuw = 6'h29, AluRemw  = 6'h2A,
    AluRemuw  = 6'h2B
  } alu_op_e;

  // Instruction format class a code maps to; selects packing and legality checks.
  typedef enum logic [2:0] {
    KindNop, KindImm, KindSh64, KindShW, KindReg, KindBad
  } ins_kind_e;

  localparam logic [6:0]  OpcOpImm   = 7'h13;
  localparam logic [6:0]  OpcOp      = 7'h33;
  localparam logic [6:0]  OpcOpImm32 = 7'h1B;
  localparam logic [6:0]  OpcOp32    = 7'h3B;
  localparam logic [31:0] NopIns     = 32'h0000_0013;

endpackage

// File: rtl/alu_ins_encode_comb.sv
// Pure combinational ALU-op to RV64IM word encoder with legality check;
// illegal ops produce the canonical NOP and raise err_o.
module alu_ins_encode_comb
  import alu_ops_pkg::*;
#(
  parameter int unsigned BusDataWidth = 64
) (
  input  logic [5:0]              alu_control_i,
  input  logic [4:0]              rs1_i,
  input  logic [4:0]              rs2_i,
  input  logic [4:0]              rd_i,
  input  logic [BusDataWidth-1:0] imm_i,
  input  logic                    muxb_i,
  output logic [31:0]             ins_o,
  output logic                    err_o
);

  alu_op_e    op;
  ins_kind_e  kind;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       imm12_ok, sh64_ok, shw_ok;

  assign op = alu_op_e'(alu_control_i);

  // 12-bit signed fit: all bits above bit 11 must copy the sign bit.
  assign imm12_ok = (&imm_i[BusDataWidth-1:11]) | ~(|imm_i[BusDataWidth-1:11]);
  assign sh64_ok  = ~(|imm_i[BusDataWidth-1:6]);
  assign shw_ok   = ~(|imm_i[BusDataWidth-1:5]);

  always_comb begin
    kind   = KindBad;
    opcode = OpcOp;
    funct3 = 3'd0;
    funct7 = 7'h00;
    unique case (op)
      AluNop:    kind = KindNop;
      AluAddi:   begin kind = KindImm;  opcode = OpcOpImm; funct3 = 3'd0; end
      AluSlti:   begin kind = KindImm;  opcode = OpcOpImm; funct3 = 3'd2; end
      AluSltiu:  begin kind = KindImm;  opcode = OpcOpImm; funct3 = 3'd3; end
      AluXori:   begin kind = KindImm;  opcode = OpcOpImm; funct3 = 3'd4; end
      AluOri:    begin kind = KindImm;  opcode = OpcOpImm; funct3 = 3'd6; end
      AluAndi:   begin kind = KindImm;  opcode = OpcOpImm; funct3 = 3'd7; end
      AluSlli:   begin kind = KindSh64; opcode = OpcOpImm; funct3 = 3'd1; end
      AluSrli:   begin kind = KindSh64; opcode = OpcOpImm; funct3 = 3'd5; end
      AluSrai:   begin kind = KindSh64; opcode = OpcOpImm; funct3 = 3'd5; funct7 = 7'h20; end
      AluAdd:    begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd0; end
      AluSub:    begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd0; funct7 = 7'h20; end
      AluSll:    begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd1; end
      AluSlt:    begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd2; end
      AluSltu:   begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd3; end
      AluXor:    begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd4; end
      AluSrl:    begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd5; end
      AluSra:    begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd5; funct7 = 7'h20; end
      AluOr:     begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd6; end
      AluAnd:    begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd7; end
      AluAddiw:  begin kind = KindImm;  opcode = OpcOpImm32; funct3 = 3'd0; end
      AluSlliw:  begin kind = KindShW;  opcode = OpcOpImm32; funct3 = 3'd1; end
      AluSrliw:  begin kind = KindShW;  opcode = OpcOpImm32; funct3 = 3'd5; end
      AluSraiw:  begin kind = KindShW;  opcode = OpcOpImm32; funct3 = 3'd5; funct7 = 7'h20; end
      AluAddw:   begin kind = KindReg;  opcode = OpcOp32;  funct3 = 3'd0; end
      AluSubw:   begin kind = KindReg;  opcode = OpcOp32;  funct3 = 3'd0; funct7 = 7'h20; end
      AluSllw:   begin kind = KindReg;  opcode = OpcOp32;  funct3 = 3'd1; end
      AluSrlw:   begin kind = KindReg;  opcode = OpcOp32;  funct3 = 3'd5; end
      AluSraw:   begin kind = KindReg;  opcode = OpcOp32;  funct3 = 3'd5; funct7 = 7'h20; end
      AluMul:    begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd0; funct7 = 7'h01; end
      AluMulh:   begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd1; funct7 = 7'h01; end
      AluMulhsu: begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd2; funct7 = 7'h01; end
      AluMulhu:  begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd3; funct7 = 7'h01; end
      AluDiv:    begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd4; funct7 = 7'h01; end
      AluDivu:   begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd5; funct7 = 7'h01; end
      AluRem:    begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd6; funct7 = 7'h01; end
      AluRemu:   begin kind = KindReg;  opcode = OpcOp;    funct3 = 3'd7; funct7 = 7'h01; end
      AluMulw:   begin kind = KindReg;  opcode = OpcOp32;  funct3 = 3'd0; funct7 = 7'h01; end
      AluDivw:   begin kind = KindReg;  opcode = OpcOp32;  funct3 = 3'd4; funct7 = 7'h01; end
      AluDivuw:  begin kind = KindReg;  opcode = OpcOp32;  funct3 = 3'd5; funct7 = 7'h01; end
      AluRemw:   begin kind = KindReg;  opcode = OpcOp32;  funct3 = 3'd6; funct7 = 7'h01; end
      AluRemuw:  begin kind = KindReg;  opcode = OpcOp32;  funct3 = 3'd7; funct7 = 7'h01; end
      default:   kind = KindBad;
    endcase

    ins_o = NopIns;
    err_o = 1'b0;
    unique case (kind)
      KindNop: ins_o = NopIns;
      KindImm: begin
        if (muxb_i && imm12_ok) ins_o = {imm_i[11:0], rs1_i, funct3, rd_i, opcode};
        else                    err_o = 1'b1;
      end
      // 64-bit shifts carry a 6-bit shamt, so only funct7[6:1] survives.
      KindSh64: begin
        if (muxb_i && sh64_ok) ins_o = {funct7[6:1], imm_i[5:0], rs1_i, funct3, rd_i, opcode};
        else                   err_o = 1'b1;
      end
      KindShW: begin
        if (muxb_i && shw_ok) ins_o = {funct7, imm_i[4:0], rs1_i, funct3, rd_i, opcode};
        else                  err_o = 1'b1;
      end
      KindReg: begin
        if (!muxb_i) ins_o = {funct7, rs2_i, rs1_i, funct3, rd_i, opcode};
        else         err_o = 1'b1;
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ins_encoder.sv
// ALU micro-op to instruction-word encoder: one-deep registered output with
// valid/ready on both sides and a saturating count of rejected ops.
module alu_ins_encoder
  import alu_ops_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned ERR_CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                in_alu_control,
  input  logic [4:0]                in_addressA,
  input  logic [4:0]                in_addressB,
  input  logic [4:0]                in_addressC,
  input  logic [BUS_DATA_WIDTH-1:0] in_imm,
  input  logic                      in_muxB_control,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_ins,
  output logic                      out_err,
  output logic [ERR_CNT_WIDTH-1:0]  err_count
);

  logic                     accept;
  logic [31:0]              enc_ins;
  logic                     enc_err;
  logic                     out_valid_q, out_valid_d;
  logic [31:0]              out_ins_q, out_ins_d;
  logic                     out_err_q, out_err_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

  alu_ins_encode_comb #(
    .BusDataWidth (BUS_DATA_WIDTH)
  ) u_encode (
    .alu_control_i (in_alu_control),
    .rs1_i         (in_addressA),
    .rs2_i         (in_addressB),
    .rd_i          (in_addressC),
    .imm_i         (in_imm),
    .muxb_i        (in_muxB_control),
    .ins_o         (enc_ins),
    .err_o         (enc_err)
  );

  // Slot is free when empty or being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_ins_d   = out_ins_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_ins_d   = enc_ins;
      out_err_d   = enc_err;
      if (enc_err && (err_count_q != {ERR_CNT_WIDTH{1'b1}})) begin
        err_count_d = err_count_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_ins_q   <= '0;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ins_q   <= out_ins_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ins   = out_ins_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;

endmodule
